vga_timing: RTL

VGA raster timing generator and output stage driving the ADV7123-style video DAC pins of the `fpga` top level. It runs on the pixel clock, scans the frame with horizontal and vertical counters, and issues pixel coordinate requests to the upstream image source. It accepts that source's RGB reply after a fixed latency and aligns sync and blanking to the returned data, so all DAC pins change on the same edge.

---
 rtl/vga_timing_if.sv | 30 +++
 rtl/vga_timing.sv | 133 +++++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
// Pixel request / reply bus between the VGA raster generator and the upstream
// image source.
//   PIX_REQ     current raster position lies in the active area
//   PIX_X       requested column (11 bits)
//   PIX_Y       requested line (10 bits)
//   FRAME_START one-cycle pulse at raster position (0,0)
//   PIX_R/G/B   pixel data returned by the source, LATENCY clocks later
// master = raster generator, slave = image source.
// -----------------------------------------------------------------------------
interface vga_timing_if;
    logic        PIX_REQ;
    logic [10:0] PIX_X;
    logic [9:0]  PIX_Y;
    logic        FRAME_START;
    logic [9:0]  PIX_R;
    logic [9:0]  PIX_G;
    logic [9:0]  PIX_B;

    modport master (
        output PIX_REQ, PIX_X, PIX_Y, FRAME_START,
        input  PIX_R, PIX_G, PIX_B
    );

    modport slave (
        input  PIX_REQ, PIX_X, PIX_Y, FRAME_START,
        output PIX_R, PIX_G, PIX_B
    );
endinterface

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// VGA raster timing generator and DAC output stage. Horizontal/vertical
// counters scan the frame and request pixels from the upstream source; sync
// and blank are delayed through a LATENCY+1 deep shift line so that they
// leave on the same edge as the registered RGB reply.
// Ports:
//   CLK        pixel clock (rising edge)
//   NRST       asynchronous active-low reset
//   pix        request/reply bus to the image source (master side)
//   VGA_CLK    inverted pixel clock for the DAC
//   VGA_HS/VS  syncs, active low
//   VGA_BLANK  0 = blanked
//   VGA_SYNC   tied 0
//   VGA_R/G/B  DAC data, 10 bits each
// LATENCY is the source read latency, legal range 0..8.
// -----------------------------------------------------------------------------
module vga_timing #(
    parameter int HDISP   = 640,
    parameter int HFP     = 16,
    parameter int HPULSE  = 96,
    parameter int HBP     = 48,
    parameter int VDISP   = 480,
    parameter int VFP     = 10,
    parameter int VPULSE  = 2,
    parameter int VBP     = 33,
    parameter int LATENCY = 2
) (
    input  logic           CLK,
    input  logic           NRST,
    vga_timing_if.master   pix,
    output logic           VGA_CLK,
    output logic           VGA_HS,
    output logic           VGA_VS,
    output logic           VGA_BLANK,
    output logic           VGA_SYNC,
    output logic [9:0]     VGA_R,
    output logic [9:0]     VGA_G,
    output logic [9:0]     VGA_B
);
    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;

    localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(VTOTAL - 1);

    // One extra bit so a sync window ending exactly at 2048/1024 still fits.
    localparam logic [11:0] H_DISP_C = 12'(HDISP);
    localparam logic [11:0] HS_ON    = 12'(HDISP + HFP);
    localparam logic [11:0] HS_OFF   = 12'(HDISP + HFP + HPULSE);
    localparam logic [10:0] V_DISP_C = 11'(VDISP);
    localparam logic [10:0] VS_ON    = 11'(VDISP + VFP);
    localparam logic [10:0] VS_OFF   = 11'(VDISP + VFP + VPULSE);

    logic [10:0]      hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    logic [LATENCY:0] hs_q, hs_d;
    logic [LATENCY:0] vs_q, vs_d;
    logic [LATENCY:0] act_q, act_d;
    logic [9:0]       r_q, r_d;
    logic [9:0]       g_q, g_d;
    logic [9:0]       b_q, b_d;

    logic hs_raw;
    logic vs_raw;
    logic active;

    always_comb begin
        hcnt_d = (hcnt_q == H_LAST) ? 11'd0 : hcnt_q + 11'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end

        // vs_raw depends on vcnt only, so it moves only when hcnt wraps.
        hs_raw = !(({1'b0, hcnt_q} >= HS_ON) && ({1'b0, hcnt_q} < HS_OFF));
        vs_raw = !(({1'b0, vcnt_q} >= VS_ON) && ({1'b0, vcnt_q} < VS_OFF));
        active = ({1'b0, hcnt_q} < H_DISP_C) && ({1'b0, vcnt_q} < V_DISP_C);

        hs_d[0]  = hs_raw;
        vs_d[0]  = vs_raw;
        act_d[0] = active;
        for (int i = 1; i <= LATENCY; i++) begin
            hs_d[i]  = hs_q[i-1];
            vs_d[i]  = vs_q[i-1];
            act_d[i] = act_q[i-1];
        end

        // act_d[LATENCY] is the active flag of the request whose reply is on
        // PIX_* right now; it loads into the last stage on this same edge.
        r_d = act_d[LATENCY] ? pix.PIX_R : 10'd0;
        g_d = act_d[LATENCY] ? pix.PIX_G : 10'd0;
        b_d = act_d[LATENCY] ? pix.PIX_B : 10'd0;
    end

    // Counters park at the last position so the first edge after release
    // lands on (0,0).
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            hcnt_q <= H_LAST;
            vcnt_q <= V_LAST;
            hs_q   <= '1;
            vs_q   <= '1;
            act_q  <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            act_q  <= act_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
        end
    end

    assign pix.PIX_REQ     = active;
    assign pix.PIX_X       = hcnt_q;
    assign pix.PIX_Y       = vcnt_q;
    assign pix.FRAME_START = (hcnt_q == 11'd0) && (vcnt_q == 10'd0);

    assign VGA_CLK   = ~CLK;
    assign VGA_HS    = hs_q[LATENCY];
    assign VGA_VS    = vs_q[LATENCY];
    assign VGA_BLANK = act_q[LATENCY];
    assign VGA_SYNC  = 1'b0;
    assign VGA_R     = r_q;
    assign VGA_G     = g_q;
    assign VGA_B     = b_q;
endmodule
